bcd_seven_seg_scan: RTL
=======================

Name: bcd_seven_seg_scan

Overview:
- Downstream consumer of the 4-bit binary-to-BCD converter.
- Accepts its 5-bit BCD result: tens bit plus a ones digit.
- Latches the value on a strobe and drives a two-digit, time-multiplexed seven-segment display.
- Blanks the display between digits to suppress ghosting, and updates the displayed value only at frame boundaries so the two digits never tear.

Parameters:
- REFRESH_DIV, 4096: clock cycles each digit is lit; legal range ≥1.
- BLANK_CYC, 4: clock cycles all digits are off between digits; legal range ≥1.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- load, input, 1: one-cycle strobe; captures bcd_in into the shadow register.
- bcd_in, input, 5: [4] = tens bit (upstream f4), [3:0] = ones digit (upstream f3..f0).
- seg, output, 7: {g,f,e,d,c,b,a}, active-high segments.
- an, output, 2: digit enables, active-low; [0] = ones, [1] = tens.
- frame_tick, output, 1: one-cycle pulse when a new frame starts (display register captured).
- err, output, 1: high while the displayed value has ones digit > 9.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = OFF0, cycle counter = 0, shadow = 0, disp = 0.
  - seg = 7'h00, an = 2'b11, frame_tick = 0, err = 0.
- Shadow register: loads bcd_in on any edge with load=1, in every state.
- FSM: OFF0 → ONES → OFF1 → TENS → OFF0.
  - OFF states last BLANK_CYC cycles; ONES and TENS last REFRESH_DIV cycles.
  - Counter clears on every transition.
  - Frame period = 2*(REFRESH_DIV+BLANK_CYC) cycles.
- Capture: on the OFF0→ONES edge, disp ← shadow, and frame_tick = 1 for the following cycle.
  - If load=1 on that same edge, disp takes bcd_in directly (bypass); shadow also updates.
- A load outside the capture edge never alters the digits of the current frame.
- Outputs are registered, so an and seg change on the same edge as the state:
  - OFF0/OFF1: an = 2'b11, seg = 7'h00.
  - ONES: an = 2'b10, seg = decode(disp[3:0]).
  - TENS: an = 2'b01, seg = decode({3'b000, disp[4]}).
- Decode table: 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F.
- Invalid ones digit (disp[3:0] 10..15):
  - err = 1 from the capture edge onward.
  - Both ONES and TENS show dash (seg = 7'h40).
  - err clears at the next capture of a valid value.
- Counter width: $clog2(max(REFRESH_DIV, BLANK_CYC)+1). Terminal count is compared with ==, so there is no wrap-around beyond terminal.
- Reset mid-frame returns immediately to reset values; the first digit lights BLANK_CYC cycles after release.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: in TENS with disp[4] = 0 and err = 0, an = 2'b11 and seg = 7'h00; FSM timing is unchanged.
- Undefined: the tens digit always lights, showing "0" (7'h3F) when disp[4] = 0.

Test Plan (REFRESH_DIV=4, BLANK_CYC=1):
- Reset, then release with load=0:
  - cycle 0 after release: an = 11, seg = 00.
  - next 4 cycles: an = 10, seg = 3F, frame_tick high in the first of them.
  - then 1 blank cycle.
  - then 4 cycles: an = 01, seg = 3F (macro undefined).
- load=1, bcd_in = 5'b1_0011 (13) → next frame: ONES an = 10, seg = 4F; TENS an = 01, seg = 06; err = 0.
- load=1, bcd_in = 5'b0_1010 → next frame: err = 1, both digits seg = 40; then load 5'b0_0101 → following frame: err = 0, ONES seg = 6D.
- Load 5'b0_0111 during TENS of the frame showing 13 → remainder of that frame still shows 13; the next frame shows 7. Tens digit: an = 11 with LEADING_ZERO_BLANK_EN, an = 01 / seg = 3F without.
- load pulsed exactly on the OFF0→ONES edge with 5'b1_0001 → that same frame shows ones seg = 06, tens seg = 06.
- Assert rst_n=0 mid-ONES → an = 11, seg = 00, err = 0 asynchronously; after release the sequence restarts exactly as in scenario 1.

Source files
------------

// File: rtl/bcd_seven_seg_scan.sv
// -----------------------------------------------------------------------------
// bcd_seven_seg_scan
//   Latches a 5-bit BCD value (tens bit + ones digit) and drives a two-digit,
//   time-multiplexed, active-high seven-segment display with blanking gaps
//   between digits. The displayed value is only updated at frame starts, so
//   the two digits of a frame always belong to the same value.
//
// Parameters
//   REFRESH_DIV : clock cycles each digit is lit (>= 1)
//   BLANK_CYC   : clock cycles all digits are dark between digits (>= 1)
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   load       : one-cycle strobe, captures bcd_in into the shadow register
//   bcd_in     : [4] tens bit, [3:0] ones digit
//   seg        : {g,f,e,d,c,b,a}, active high
//   an         : digit enables, active low; [0] ones, [1] tens
//   frame_tick : one-cycle pulse in the first cycle of each frame
//   err        : high while the displayed ones digit is above 9
//
// Optional feature
//   LEADING_ZERO_BLANK_EN : when defined, a zero tens digit is left dark.
// -----------------------------------------------------------------------------
module bcd_seven_seg_scan #(
  parameter int unsigned REFRESH_DIV = 4096,
  parameter int unsigned BLANK_CYC   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] bcd_in,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick,
  output logic       err
);

  localparam int unsigned MAX_DUR = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_DUR + 1);

  localparam logic [CNT_W-1:0] ON_TERM  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] OFF_TERM = CNT_W'(BLANK_CYC - 1);

  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [1:0] AN_NONE  = 2'b11;
  localparam logic [1:0] AN_ONES  = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;

  typedef enum logic [1:0] {
    OFF0 = 2'd0,
    ONES = 2'd1,
    OFF1 = 2'd2,
    TENS = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       shadow;
  logic [4:0]       disp;
  logic [4:0]       cap_val;

  // A load coinciding with the capture edge bypasses the shadow register.
  assign cap_val = load ? bcd_in : shadow;

  // Plain BCD digit decode; non-decimal codes map to a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    s = SEG_DASH;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  function automatic logic is_invalid(input logic [4:0] v);
    return (v[3:0] > 4'd9);
  endfunction

  function automatic logic [6:0] ones_seg(input logic [4:0] v);
    return is_invalid(v) ? SEG_DASH : decode(v[3:0]);
  endfunction

  // Tens digit pattern; an invalid value shows a dash on both digits.
  function automatic logic [6:0] tens_seg(input logic [4:0] v);
    logic [6:0] s;
    if (is_invalid(v)) begin
      s = SEG_DASH;
    end else begin
`ifdef LEADING_ZERO_BLANK_EN
      s = v[4] ? decode(4'd1) : SEG_OFF;
`else
      s = decode({3'b000, v[4]});
`endif
    end
    return s;
  endfunction

  function automatic logic [1:0] tens_an(input logic [4:0] v);
    logic [1:0] a;
    a = AN_TENS;
`ifdef LEADING_ZERO_BLANK_EN
    if (!v[4] && !is_invalid(v)) begin
      a = AN_NONE;
    end
`endif
    return a;
  endfunction

  // Scan FSM with registered outputs; outputs change on the state edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= OFF0;
      cnt        <= '0;
      shadow     <= '0;
      disp       <= '0;
      seg        <= SEG_OFF;
      an         <= AN_NONE;
      frame_tick <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (load) begin
        shadow <= bcd_in;
      end

      case (state)
        OFF0: begin
          if (cnt == OFF_TERM) begin
            state      <= ONES;
            cnt        <= '0;
            disp       <= cap_val;
            err        <= is_invalid(cap_val);
            frame_tick <= 1'b1;
            an         <= AN_ONES;
            seg        <= ones_seg(cap_val);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ONES: begin
          if (cnt == ON_TERM) begin
            state <= OFF1;
            cnt   <= '0;
            an    <= AN_NONE;
            seg   <= SEG_OFF;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        OFF1: begin
          if (cnt == OFF_TERM) begin
            state <= TENS;
            cnt   <= '0;
            an    <= tens_an(disp);
            seg   <= tens_seg(disp);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        TENS: begin
          if (cnt == ON_TERM) begin
            state <= OFF0;
            cnt   <= '0;
            an    <= AN_NONE;
            seg   <= SEG_OFF;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= OFF0;
          cnt   <= '0;
          an    <= AN_NONE;
          seg   <= SEG_OFF;
        end
      endcase
    end
  end

endmodule
